// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// icache_pkg : shared constants, derived address-split widths and FSM states
// Revision   : 1.0
// ============================================================================
package icache_pkg;

  localparam int ARCH_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int ICLN     = 4;
  localparam int ICLLEN   = 128;

  localparam int IC_OFF_BITS = $clog2(ICLLEN / 8);
  localparam int IC_IDX_BITS = $clog2(ICLN);
  localparam int IC_TAG_BITS = ARCH_LEN - IC_OFF_BITS - IC_IDX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// icache_array : per-line valid/tag/data flops, combinational read, flash-clear
// Revision     : 1.0
// ============================================================================
module icache_array
  import icache_pkg::*;
#(
  parameter int NLINES   = ICLN,
  parameter int LINE_LEN = ICLLEN,
  parameter int IDX_BITS = IC_IDX_BITS,
  parameter int TAG_BITS = IC_TAG_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [LINE_LEN-1:0] rd_data,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_valid,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [LINE_LEN-1:0] wr_data
);

  logic [NLINES-1:0]   valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q  [NLINES];
  logic [TAG_BITS-1:0] tag_d  [NLINES];
  logic [LINE_LEN-1:0] data_q [NLINES];
  logic [LINE_LEN-1:0] data_d [NLINES];

  // A write in the same cycle as a clear still decides its own line's valid.
  always_comb begin
    valid_d = clear ? '0 : valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_valid;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// icache : direct-mapped read-only instruction cache, single-beat line fill
// Revision : 1.0
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int NLINES   = ICLN,
  parameter int LINE_LEN = ICLLEN,
  parameter int ADDR_LEN = ARCH_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_LEN-1:0] req_addr,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [INST_LEN-1:0] resp_inst,
  input  logic                flush,
  output logic                mem_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [LINE_LEN-1:0] mem_rdata
);

  localparam int OFF_BITS = $clog2(LINE_LEN / 8);
  localparam int IDX_BITS = $clog2(NLINES);
  localparam int TAG_BITS = ADDR_LEN - OFF_BITS - IDX_BITS;

  icache_state_t       state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                flush_pend_q, flush_pend_d;
  logic                resp_valid_q, resp_valid_d;
  logic [INST_LEN-1:0] resp_inst_q, resp_inst_d;

  logic                arr_rd_valid;
  logic [TAG_BITS-1:0] arr_rd_tag;
  logic [LINE_LEN-1:0] arr_rd_data;
  logic                arr_clear, arr_wr_en, arr_wr_valid;
  logic                lookup_hit;

  // Byte offset with bits [1:0] masked, turned into a bit shift of the line.
  function automatic logic [INST_LEN-1:0] select_word(input logic [LINE_LEN-1:0] line,
                                                      input logic [OFF_BITS-1:0] byte_off);
    logic [OFF_BITS-1:0] aligned;
    logic [LINE_LEN-1:0] shifted;
    aligned = byte_off & ~OFF_BITS'(3);
    shifted = line >> {aligned, 3'b000};
    return shifted[INST_LEN-1:0];
  endfunction

  icache_array #(
    .NLINES   (NLINES),
    .LINE_LEN (LINE_LEN),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_addr[OFF_BITS +: IDX_BITS]),
    .rd_valid (arr_rd_valid),
    .rd_tag   (arr_rd_tag),
    .rd_data  (arr_rd_data),
    .clear    (arr_clear),
    .wr_en    (arr_wr_en),
    .wr_idx   (addr_q[OFF_BITS +: IDX_BITS]),
    .wr_valid (arr_wr_valid),
    .wr_tag   (addr_q[ADDR_LEN-1 -: TAG_BITS]),
    .wr_data  (mem_rdata)
  );

  assign lookup_hit = arr_rd_valid && (arr_rd_tag == req_addr[ADDR_LEN-1 -: TAG_BITS]);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    resp_valid_d = 1'b0;
    resp_inst_d  = resp_inst_q;
    arr_clear    = 1'b0;
    arr_wr_en    = 1'b0;
    arr_wr_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (flush) begin
          arr_clear = 1'b1;
        end else if (req_valid) begin
          if (lookup_hit) begin
            resp_valid_d = 1'b1;
            resp_inst_d  = select_word(arr_rd_data, req_addr[OFF_BITS-1:0]);
          end else begin
            addr_d  = req_addr;
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        if (flush) begin
          flush_pend_d = 1'b1;
          arr_clear    = 1'b1;
        end
        if (mem_gnt) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (flush) begin
          flush_pend_d = 1'b1;
          arr_clear    = 1'b1;
        end
        // A flush seen at any point during the miss keeps the filled line invalid.
        if (mem_rvalid) begin
          arr_wr_en    = 1'b1;
          arr_wr_valid = !(flush_pend_q || flush);
          resp_valid_d = 1'b1;
          resp_inst_d  = select_word(mem_rdata, addr_q[OFF_BITS-1:0]);
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !flush;
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign mem_req    = (state_q == MISS_REQ);
  assign mem_addr   = (state_q == MISS_REQ) ?
                      {addr_q[ADDR_LEN-1:OFF_BITS], {OFF_BITS{1'b0}}} : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// tb_icache : scenario and randomized checks of icache against a line model
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_inst;
  logic         flush = 1'b0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [127:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  // Model: which line-aligned address each index currently holds.
  logic        m_v    [4];
  logic [31:0] m_line [4];

  always #5 clk = ~clk;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [127:0] line_data(input logic [31:0] la);
    logic [127:0] d;
    if (la == 32'h0000_1000) return 128'h44444444_33333333_22222222_11111111;
    for (int w = 0; w < 4; w++) d[32*w +: 32] = (la * 32'h9E3779B1) ^ (32'(w + 1) * 32'h85EBCA77);
    return d;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    logic [127:0] d;
    d = line_data(a & ~32'hF);
    return d[32*a[3:2] +: 32];
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return m_v[a[5:4]] && (m_line[a[5:4]] == (a & ~32'hF));
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_v[a[5:4]]    = 1'b1;
    m_line[a[5:4]] = a & ~32'hF;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
  endtask

  // Issues one request and plays memory; lat is cycles from acceptance to resp (0 = timeout).
  task automatic fetch(input logic [31:0] a, input int gd, input int rd, input int flush_at,
                       output int lat, output logic [31:0] inst, output logic missed,
                       output logic [31:0] maddr, output logic stable, output logic rdy_low);
    int gw, rw;
    logic granted;
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    lat = 0; inst = '0; missed = 1'b0; maddr = '0; stable = 1'b1; rdy_low = 1'b1;
    gw = 0; rw = 0; granted = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      flush      = (k == flush_at);
      #1;
      if (resp_valid) begin
        lat  = k;
        inst = resp_inst;
        break;
      end
      if (req_ready) rdy_low = 1'b0;
      if (mem_req) begin
        if (!missed) maddr = mem_addr;
        else if (mem_addr !== maddr) stable = 1'b0;
        missed = 1'b1;
        if (gw >= gd) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end else gw++;
      end else if (granted) begin
        if (rw >= rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = line_data(maddr);
        end else rw++;
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_vec++; if (resp_inst !== 32'h0) begin n_err++; $display("FAIL reset_resp_inst: got %h expected 0", resp_inst); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    model_clear();
  endtask

  task automatic test_cold_boot;
    int lat; logic [31:0] inst, maddr; logic missed, stable, rdy_low;
    fetch(32'h1000, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL cold_miss: got %b expected 1", missed); end
    n_vec++; if (maddr !== 32'h1000) begin n_err++; $display("FAIL cold_mem_addr: got %h expected 00001000", maddr); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL cold_latency: got %0d expected 3", lat); end
    n_vec++; if (inst !== 32'h11111111) begin n_err++; $display("FAIL cold_inst: got %h expected 11111111", inst); end
    model_fill(32'h1000);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs[0] = 32'h1004; addrs[1] = 32'h1008; addrs[2] = 32'h100C;
    exps[0]  = 32'h22222222; exps[1] = 32'h33333333; exps[2] = 32'h44444444;
    req_valid = 1'b1;
    req_addr  = addrs[0];
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) req_addr = addrs[i+1];
      else req_valid = 1'b0;
      #1;
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, resp_valid); end
      n_vec++; if (resp_inst !== exps[i]) begin n_err++; $display("FAIL b2b_inst[%0d]: got %h expected %h", i, resp_inst, exps[i]); end
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_mem_req[%0d]: got %b expected 0", i, mem_req); end
      @(posedge clk); #1;
    end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail: got %b expected 0", resp_valid); end
  endtask

  task automatic test_conflict;
    int lat; logic [31:0] inst, maddr; logic missed, stable, rdy_low;
    fetch(32'h1040, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL conflict_miss1: got %b expected 1", missed); end
    n_vec++; if (maddr !== 32'h1040) begin n_err++; $display("FAIL conflict_addr1: got %h expected 00001040", maddr); end
    n_vec++; if (inst !== exp_inst(32'h1040)) begin n_err++; $display("FAIL conflict_inst1: got %h expected %h", inst, exp_inst(32'h1040)); end
    model_fill(32'h1040);
    fetch(32'h1000, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL conflict_miss2: got %b expected 1", missed); end
    n_vec++; if (maddr !== 32'h1000) begin n_err++; $display("FAIL conflict_addr2: got %h expected 00001000", maddr); end
    n_vec++; if (inst !== 32'h11111111) begin n_err++; $display("FAIL conflict_inst2: got %h expected 11111111", inst); end
    model_fill(32'h1000);
  endtask

  task automatic test_held_grant;
    int lat; logic [31:0] inst, maddr; logic missed, stable, rdy_low;
    fetch(32'h2008, 3, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL held_latency: got %0d expected 6", lat); end
    n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL held_addr_stable: got %b expected 1", stable); end
    n_vec++; if (rdy_low !== 1'b1) begin n_err++; $display("FAIL held_ready_low: got %b expected 1", rdy_low); end
    n_vec++; if (maddr !== 32'h2000) begin n_err++; $display("FAIL held_mem_addr: got %h expected 00002000", maddr); end
    n_vec++; if (inst !== exp_inst(32'h2008)) begin n_err++; $display("FAIL held_inst: got %h expected %h", inst, exp_inst(32'h2008)); end
    model_fill(32'h2008);
  endtask

  task automatic test_flush;
    int lat; logic [31:0] inst, maddr; logic missed, stable, rdy_low;
    fetch(32'h1004, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    model_fill(32'h1004);
    fetch(32'h1004, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b0 || lat != 1) begin n_err++; $display("FAIL flush_prehit: got miss=%b lat=%0d expected miss=0 lat=1", missed, lat); end
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h1004;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    n_vec++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL flush_idle_noaccept: got resp=%b mem_req=%b expected 0 0", resp_valid, mem_req); end
    model_clear();
    fetch(32'h1004, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL flush_idle_remiss: got %b expected 1", missed); end
    model_fill(32'h1004);
    fetch(32'h1010, 0, 2, 2, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL flush_wait_latency: got %0d expected 5", lat); end
    n_vec++; if (inst !== exp_inst(32'h1010)) begin n_err++; $display("FAIL flush_wait_inst: got %h expected %h", inst, exp_inst(32'h1010)); end
    model_clear();
    fetch(32'h1010, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL flush_wait_same_remiss: got %b expected 1", missed); end
    model_fill(32'h1010);
    fetch(32'h1004, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL flush_wait_other_remiss: got %b expected 1", missed); end
    model_fill(32'h1004);
  endtask

  task automatic test_reset_mid_fill;
    int lat; logic [31:0] inst, maddr; logic missed, stable, rdy_low;
    req_valid = 1'b1; req_addr = 32'h3000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rmf_mem_req: got %b expected 1", mem_req); end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rmf_wait_ready: got %b expected 0", req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL rmf_after_rst: got mem_req=%b resp=%b expected 0 0", mem_req, resp_valid); end
    mem_rvalid = 1'b1; mem_rdata = line_data(32'h3000);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    #1;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rmf_stray_rvalid: got %b expected 0", resp_valid); end
    model_clear();
    fetch(32'h1000, 0, 0, 0, lat, inst, missed, maddr, stable, rdy_low);
    n_vec++; if (missed !== 1'b1 || inst !== 32'h11111111) begin n_err++; $display("FAIL rmf_remiss: got miss=%b inst=%h expected 1 11111111", missed, inst); end
    model_fill(32'h1000);
  endtask

  task automatic test_random;
    int lat, gd, rd, exp_lat; logic [31:0] a, inst, maddr; logic missed, stable, rdy_low, exp_hit;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1; req_valid = $urandom_range(0, 1); req_addr = $urandom;
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rnd_flush_ready[%0d]: got %b expected 0", it, req_ready); end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        model_clear();
      end
      a  = 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      exp_hit = model_hit(a);
      exp_lat = exp_hit ? 1 : 3 + gd + rd;
      fetch(a, gd, rd, 0, lat, inst, missed, maddr, stable, rdy_low);
      n_vec++; if (missed !== !exp_hit) begin n_err++; $display("FAIL rnd_miss[%0d] addr %h: got %b expected %b", it, a, missed, !exp_hit); end
      n_vec++; if (lat != exp_lat) begin n_err++; $display("FAIL rnd_latency[%0d] addr %h: got %0d expected %0d", it, a, lat, exp_lat); end
      n_vec++; if (inst !== exp_inst(a)) begin n_err++; $display("FAIL rnd_inst[%0d] addr %h: got %h expected %h", it, a, inst, exp_inst(a)); end
      if (!exp_hit) begin
        n_vec++; if (maddr !== (a & ~32'hF) || stable !== 1'b1) begin n_err++; $display("FAIL rnd_mem_addr[%0d]: got %h stable=%b expected %h", it, maddr, stable, a & ~32'hF); end
        model_fill(a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_boot();
    test_back_to_back();
    test_conflict();
    test_held_grant();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
